// File: rtl/regfile_pkg.sv
// Shared constants and flattened-port indexing helpers for the register file.
package regfile_pkg;

    localparam int unsigned RADDRWIDTH_DEF = 3;
    localparam int unsigned REGWIDTH_DEF   = 16;

    // Low bit of slice idx in a flattened bus of width-bit fields.
    function automatic int unsigned rf_lo(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy bits for pending long-latency results plus a registered population count.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned RADDRWIDTH = RADDRWIDTH_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        rsv,
    input  logic [RADDRWIDTH-1:0]       rsv_addr,
    input  logic                        we1,
    input  logic [RADDRWIDTH-1:0]       waddr1,
    output logic [(2**RADDRWIDTH)-1:0]  busy,
    output logic [RADDRWIDTH:0]         pend_cnt
);

    localparam int unsigned NREG = 2**RADDRWIDTH;
    localparam int unsigned CW   = RADDRWIDTH + 1;

    logic [NREG-1:0] busy_nxt;
    logic [CW-1:0]   cnt_nxt;

    // A reserve names a new producer, so it beats a same-cycle W1 clear.
    always_comb begin
        busy_nxt = busy;
        cnt_nxt  = '0;
        for (int unsigned r = 1; r < NREG; r++) begin
            if (rsv && rsv_addr == RADDRWIDTH'(r)) begin
                busy_nxt[RADDRWIDTH'(r)] = 1'b1;
            end else if (we1 && waddr1 == RADDRWIDTH'(r)) begin
                busy_nxt[RADDRWIDTH'(r)] = 1'b0;
            end
        end
        busy_nxt[0] = 1'b0;
        for (int unsigned r = 1; r < NREG; r++) begin
            cnt_nxt = cnt_nxt + CW'(busy_nxt[RADDRWIDTH'(r)]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy     <= '0;
            pend_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            pend_cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-read, dual-write register file with optional write bypass and a busy scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned RADDRWIDTH = RADDRWIDTH_DEF,
    parameter int unsigned REGWIDTH   = REGWIDTH_DEF,
    parameter int unsigned NREAD      = 2,
    parameter int unsigned BYPASS     = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NREAD*RADDRWIDTH-1:0]   raddr,
    output logic [NREAD*REGWIDTH-1:0]     rdata,
    output logic [NREAD-1:0]              rbusy,
    input  logic                          we0,
    input  logic [RADDRWIDTH-1:0]         waddr0,
    input  logic [REGWIDTH-1:0]           wdata0,
    input  logic                          we1,
    input  logic [RADDRWIDTH-1:0]         waddr1,
    input  logic [REGWIDTH-1:0]           wdata1,
    input  logic                          rsv,
    input  logic [RADDRWIDTH-1:0]         rsv_addr,
    output logic [RADDRWIDTH:0]           pend_cnt
);

    localparam int unsigned NREG = 2**RADDRWIDTH;

    logic [REGWIDTH-1:0] mem [1:NREG-1];
    logic [NREG-1:0]     busy;

    regfile_scoreboard #(.RADDRWIDTH(RADDRWIDTH)) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .rsv      (rsv),
        .rsv_addr (rsv_addr),
        .we1      (we1),
        .waddr1   (waddr1),
        .busy     (busy),
        .pend_cnt (pend_cnt)
    );

    // W0 wins a same-address collision; r0 has no storage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned r = 1; r < NREG; r++) begin
                mem[RADDRWIDTH'(r)] <= '0;
            end
        end else begin
            for (int unsigned r = 1; r < NREG; r++) begin
                if (we0 && waddr0 == RADDRWIDTH'(r)) begin
                    mem[RADDRWIDTH'(r)] <= wdata0;
                end else if (we1 && waddr1 == RADDRWIDTH'(r)) begin
                    mem[RADDRWIDTH'(r)] <= wdata1;
                end
            end
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [RADDRWIDTH-1:0] ra;
        logic [REGWIDTH-1:0]   stored;
        logic [REGWIDTH-1:0]   rd;
        logic                  rb;

        assign ra = raddr[rf_lo(i, RADDRWIDTH) +: RADDRWIDTH];

        always_comb begin
            stored = '0;
            for (int unsigned r = 1; r < NREG; r++) begin
                if (ra == RADDRWIDTH'(r)) begin
                    stored = mem[RADDRWIDTH'(r)];
                end
            end
            rd = stored;
            rb = busy[ra];
            if (ra == '0) begin
                rd = '0;
                rb = 1'b0;
            end else if (BYPASS != 0) begin
                if (we0 && waddr0 == ra) begin
                    rd = wdata0;
                end else if (we1 && waddr1 == ra) begin
                    rd = wdata1;
                end
                // The W1 producer is completing now, so decode need not stall.
                if (we1 && waddr1 == ra) begin
                    rb = 1'b0;
                end
            end
        end

        assign rdata[rf_lo(i, REGWIDTH) +: REGWIDTH] = rd;
        assign rbusy[i] = rb;
    end

endmodule
